// File: rtl/flash_loader.sv
// Bulk copier: reads LENGTH bytes from the SPI flash reader starting at SRC and
// writes each one to a memory port starting at DST, one byte in flight at a time.
module flash_loader #(
  parameter int unsigned MEM_AW  = 24,
  parameter int unsigned LEN_W   = 24,
  parameter int unsigned BUSY_TO = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [23:0]       src_addr,
  input  logic [MEM_AW-1:0] dst_addr,
  input  logic [LEN_W-1:0]  length,
  input  logic              flash_ready,
  input  logic              flash_busy,
  input  logic [7:0]        flash_dout,
  output logic [23:0]       flash_addr,
  output logic              flash_cs,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [7:0]        mem_din,
  output logic              mem_we,
  input  logic              mem_ack,
  output logic              active,
  output logic              done,
  output logic              error,
  output logic [LEN_W-1:0]  count
);

  localparam int unsigned TO_W = $clog2(BUSY_TO + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_RDY,
    S_REQ,
    S_WAIT_DATA,
    S_WRITE
  } state_e;

  state_e            state_q;
  logic [23:0]       src_q;
  logic [MEM_AW-1:0] dst_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  count_q;
  logic [TO_W-1:0]   to_q;
  logic [23:0]       flash_addr_q;
  logic              flash_cs_q;
  logic [MEM_AW-1:0] mem_addr_q;
  logic [7:0]        mem_din_q;
  logic              mem_we_q;
  logic              active_q;
  logic              done_q;
  logic              error_q;

  logic [23:0]       flash_addr_d;
  logic [MEM_AW-1:0] mem_addr_d;
  logic [LEN_W-1:0]  count_d;

  // Addresses are formed from the running count so both sides wrap naturally.
  always_comb begin
    flash_addr_d = src_q + 24'(count_q);
    mem_addr_d   = dst_q + MEM_AW'(count_q);
    count_d      = count_q + LEN_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      src_q        <= '0;
      dst_q        <= '0;
      len_q        <= '0;
      count_q      <= '0;
      to_q         <= '0;
      flash_addr_q <= '0;
      flash_cs_q   <= 1'b0;
      mem_addr_q   <= '0;
      mem_din_q    <= '0;
      mem_we_q     <= 1'b0;
      active_q     <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            src_q   <= src_addr;
            dst_q   <= dst_addr;
            len_q   <= length;
            count_q <= '0;
            error_q <= 1'b0;
            if (length == '0) begin
              done_q <= 1'b1;
            end else begin
              active_q <= 1'b1;
              state_q  <= S_WAIT_RDY;
            end
          end
        end
        // Waiting on !busy also keeps us clear of a read left over from a reset.
        S_WAIT_RDY: begin
          if (flash_ready && !flash_busy) begin
            flash_cs_q   <= 1'b1;
            flash_addr_q <= flash_addr_d;
            to_q         <= '0;
            state_q      <= S_REQ;
          end
        end
        S_REQ: begin
          if (flash_busy) begin
            flash_cs_q <= 1'b0;
            state_q    <= S_WAIT_DATA;
          end else if (to_q == TO_W'(BUSY_TO - 1)) begin
            flash_cs_q <= 1'b0;
            error_q    <= 1'b1;
            active_q   <= 1'b0;
            state_q    <= S_IDLE;
          end else begin
            to_q <= to_q + TO_W'(1);
          end
        end
        S_WAIT_DATA: begin
          if (!flash_busy) begin
            mem_din_q  <= flash_dout;
            mem_addr_q <= mem_addr_d;
            mem_we_q   <= 1'b1;
            state_q    <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (mem_ack) begin
            mem_we_q <= 1'b0;
            count_q  <= count_d;
            if (count_d == len_q) begin
              done_q   <= 1'b1;
              active_q <= 1'b0;
              state_q  <= S_IDLE;
            end else begin
              state_q <= S_WAIT_RDY;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign flash_addr = flash_addr_q;
  assign flash_cs   = flash_cs_q;
  assign mem_addr   = mem_addr_q;
  assign mem_din    = mem_din_q;
  assign mem_we     = mem_we_q;
  assign active     = active_q;
  assign done       = done_q;
  assign error      = error_q;
  assign count      = count_q;

endmodule
